// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and its multiplier handshake.
package modexp_ctrl_pkg;

    localparam int unsigned BITS  = 31;
    localparam int unsigned EBITS = 31;
    localparam int unsigned DW    = BITS + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONV_X   = 3'd1,
        CONV_A   = 3'd2,
        SQR      = 3'd3,
        MUL      = 3'd4,
        CONV_OUT = 3'd5,
        FIN      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_ISSUE = 2'd1,
        MM_WAIT  = 2'd2
    } mm_phase_t;

    localparam logic [BITS:0] ONE = DW'(1);

    // Multiplier request/response payloads as seen on the mm_* ports.
    typedef struct packed {
        logic          start;
        logic [BITS:0] a;
        logic [BITS:0] b;
    } mm_req_t;

    typedef struct packed {
        logic          done;
        logic [BITS:0] y;
    } mm_rsp_t;

endpackage

// File: rtl/modexp_ctrl_mm_issue.sv
// One multiplier transaction: latch operands, pulse mm_start, hold until mm_done.
module modexp_ctrl_mm_issue
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned bits = BITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [bits:0] op_a,
    input  logic [bits:0] op_b,
    input  logic          mm_done,
    input  logic [bits:0] mm_y,
    output logic [bits:0] mm_a,
    output logic [bits:0] mm_b,
    output logic          mm_start,
    output logic          cap_c,
    output logic [bits:0] res_c
);

    mm_phase_t phase;
    logic      accept;

    // A new request may be taken in the same cycle the previous result lands.
    assign cap_c  = (phase == MM_WAIT) && mm_done;
    assign accept = go && ((phase == MM_IDLE) || cap_c);
    assign res_c  = mm_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase    <= MM_IDLE;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
        end else begin
            mm_start <= accept;
            if (accept) begin
                mm_a  <= op_a;
                mm_b  <= op_b;
                phase <= MM_ISSUE;
            end else if (phase == MM_ISSUE) begin
                phase <= MM_WAIT;
            end else if (cap_c) begin
                phase <= MM_IDLE;
            end
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned bits  = BITS,
    parameter int unsigned ebits = EBITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [bits:0] msg,
    input  logic [ebits:0] e,
    input  logic [bits:0] N,
    input  logic [bits:0] r2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [bits:0] y,
    output logic [bits:0] mm_a,
    output logic [bits:0] mm_b,
    output logic          mm_start,
    input  logic          mm_done,
    input  logic [bits:0] mm_y,
    output logic [2:0]    stateO
);

    localparam int unsigned W  = bits + 1;
    localparam int unsigned IW = (ebits > 0) ? $clog2(ebits + 1) : 1;

    state_t         state, nxt_c;
    logic           go_c, dec_c, cap_c;
    logic [bits:0]  op_a_c, op_b_c, res_c;
    logic [IW-1:0]  idx;
    logic [ebits:0] e_reg;
    logic [bits:0]  r2_reg, x_reg;
    logic           unused_n;

    // Only the parity of N matters here; reduction lives in the multiplier.
    assign unused_n = ^N[bits:1];
    assign stateO   = state;

    modexp_ctrl_mm_issue #(.bits(bits)) u_issue (
        .clk      (clk),
        .reset    (reset),
        .go       (go_c),
        .op_a     (op_a_c),
        .op_b     (op_b_c),
        .mm_done  (mm_done),
        .mm_y     (mm_y),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_start (mm_start),
        .cap_c    (cap_c),
        .res_c    (res_c)
    );

    // Next state and the operands of the transaction issued on that edge.
    always_comb begin
        nxt_c  = state;
        go_c   = 1'b0;
        dec_c  = 1'b0;
        op_a_c = res_c;
        op_b_c = res_c;
        case (state)
            IDLE: if (start) begin
                if (!N[0]) begin
                    nxt_c = FIN;
                end else begin
                    nxt_c  = CONV_X;
                    go_c   = 1'b1;
                    op_a_c = msg;
                    op_b_c = r2;
                end
            end
            CONV_X: if (cap_c) begin
                nxt_c  = CONV_A;
                go_c   = 1'b1;
                op_a_c = r2_reg;
                op_b_c = W'(ONE);
            end
            CONV_A: if (cap_c) begin
                nxt_c = SQR;
                go_c  = 1'b1;
            end
            SQR: if (cap_c) begin
                go_c = 1'b1;
                if (e_reg[idx]) begin
                    nxt_c  = MUL;
                    op_b_c = x_reg;
                end else if (idx == '0) begin
                    nxt_c  = CONV_OUT;
                    op_b_c = W'(ONE);
                end else begin
                    dec_c = 1'b1;
                end
            end
            MUL: if (cap_c) begin
                go_c = 1'b1;
                if (idx == '0) begin
                    nxt_c  = CONV_OUT;
                    op_b_c = W'(ONE);
                end else begin
                    nxt_c = SQR;
                    dec_c = 1'b1;
                end
            end
            CONV_OUT: if (cap_c) nxt_c = FIN;
            FIN:      nxt_c = IDLE;
            default:  nxt_c = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            y      <= '0;
            x_reg  <= '0;
            r2_reg <= '0;
            e_reg  <= '0;
            idx    <= '0;
        end else begin
            state <= nxt_c;
            done  <= (nxt_c == FIN);
            busy  <= (nxt_c != IDLE) && (nxt_c != FIN);
            if (state == IDLE && start) begin
                e_reg  <= e;
                r2_reg <= r2;
                err    <= ~N[0];
                if (!N[0]) y <= '0;
            end
            if (cap_c) begin
                case (state)
                    CONV_X:   x_reg <= res_c;
                    CONV_A:   idx   <= IW'(ebits);
                    CONV_OUT: y     <= res_c;
                    default:  ;
                endcase
            end
            if (dec_c) idx <= idx - IW'(1);
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioural R=2^6 Montgomery multiplier.
module tb_modexp_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] msg, e, N, r2;
    logic        busy, done, err, mm_start, mm_done;
    logic [31:0] y, mm_a, mm_b, mm_y;
    logic [2:0]  stateO;

    int     checks = 0, failures = 0;
    longint cyc = 0;
    int     n_start = 0, n_done = 0;
    longint last_mmdone = 0;
    int     spur_req = 0, spur_ack = 0;
    int     mdl_busy = 0, stab_bad = 0;
    logic   stab_chk = 1'b0;
    logic [31:0] mdl_n = 32'd1;

    typedef struct {
        logic [31:0] msg, e, n, r2, y;
        logic        err;
        int          starts;
        logic        noise;
    } vec_t;
    vec_t vt[6];

    modexp_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .msg(msg), .e(e), .N(N), .r2(r2),
        .busy(busy), .done(done), .err(err), .y(y), .mm_a(mm_a), .mm_b(mm_b),
        .mm_start(mm_start), .mm_done(mm_done), .mm_y(mm_y), .stateO(stateO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mm_start) n_start++;
        if (mm_done) last_mmdone = cyc;
        if (done) n_done++;
    end

    function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        longint nn = longint'(n);
        longint p  = (longint'(a) * longint'(b)) % nn;
        for (longint r = 0; r < nn; r++)
            if ((r * 64) % nn == p) return 32'(r);
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Behavioural multiplier: random 1..20 cycle latency, checks operand stability.
    initial begin
        logic [31:0] la, lb;
        int lat;
        mm_done = 1'b0;
        mm_y    = '0;
        forever begin
            @(posedge clk); #1;
            if (spur_req != spur_ack) begin
                mm_done = 1'b1; mm_y = 32'd9;
                @(posedge clk); #1;
                mm_done = 1'b0;
                spur_ack = spur_req;
            end
            while (mm_start) begin
                la = mm_a; lb = mm_b;
                lat = int'($urandom_range(20, 1));
                mdl_busy = 1;
                for (int c = 0; c < lat; c++) begin
                    @(posedge clk); #1;
                    if (stab_chk && (mm_a !== la || mm_b !== lb)) stab_bad++;
                end
                mm_y = mont(la, lb, mdl_n);
                mm_done = 1'b1;
                @(posedge clk); #1;
                mm_done = 1'b0;
                mdl_busy = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        longint t0;
        int s0, k;
        @(negedge clk);
        msg = v.msg; e = v.e; N = v.n; r2 = v.r2; mdl_n = v.n;
        start = 1'b1; t0 = cyc; s0 = n_start;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_t1"}, longint'(busy), longint'(!v.err));
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk); k++;
            start = v.noise && (k % 7 == 3) && !done;
            if (start) begin msg = 32'd7; e = 32'd0; N = 32'd32; r2 = 32'd1; end
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, longint'(done), 1);
        chk({tag, ".y"}, longint'(y), longint'(v.y));
        chk({tag, ".err"}, longint'(err), longint'(v.err));
        chk({tag, ".mm_starts"}, longint'(n_start - s0), longint'(v.starts));
        if (v.err) chk({tag, ".done_lat"}, cyc - t0, 1);
        else       chk({tag, ".done_lat"}, cyc - last_mmdone, 1);
        @(negedge clk);
        chk({tag, ".done_width"}, longint'(done), 0);
        chk({tag, ".busy_end"}, longint'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d0, s0;
        logic [31:0] y0;
        vt[0] = '{msg:32'd5, e:32'd3,  n:32'd33, r2:32'd4, y:32'd26, err:1'b0, starts:37, noise:1'b0};
        vt[1] = '{msg:32'd4, e:32'd13, n:32'd61, r2:32'd9, y:32'd19, err:1'b0, starts:38, noise:1'b0};
        vt[2] = '{msg:32'd7, e:32'd0,  n:32'd33, r2:32'd4, y:32'd1,  err:1'b0, starts:35, noise:1'b0};
        vt[3] = '{msg:32'd0, e:32'd5,  n:32'd33, r2:32'd4, y:32'd0,  err:1'b0, starts:37, noise:1'b0};
        vt[4] = '{msg:32'd5, e:32'd3,  n:32'd32, r2:32'd0, y:32'd0,  err:1'b1, starts:0,  noise:1'b0};
        vt[5] = '{msg:32'd5, e:32'd3,  n:32'd33, r2:32'd4, y:32'd26, err:1'b0, starts:37, noise:1'b1};

        reset = 1'b0; start = 1'b0; msg = '0; e = '0; N = '0; r2 = '0;
        #12;
        chk("reset.flags", longint'({busy, done, err, mm_start}), 0);
        chk("reset.y", longint'(y), 0);
        chk("reset.state", longint'(stateO), 0);
        @(negedge clk); reset = 1'b1;
        stab_chk = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        chk("operands_stable", longint'(stab_bad), 0);
        stab_chk = 1'b0;

        // Spurious mm_done while idle must not disturb anything.
        y0 = y; d0 = n_done; s0 = n_start;
        spur_req++;
        k = 0;
        while (spur_ack != spur_req && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("spur.state", longint'(stateO), 0);
        chk("spur.busy_done", longint'({busy, n_done - d0}), 0);
        chk("spur.mm_start", longint'(n_start - s0), 0);
        chk("spur.y", longint'(y), longint'(y0));

        // Asynchronous reset while a squaring is outstanding.
        @(negedge clk);
        msg = 32'd4; e = 32'd13; N = 32'd61; r2 = 32'd9; mdl_n = 32'd61; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(stateO == 3'd3 && !mm_start) && k < 500) begin @(negedge clk); k++; end
        chk("rst.reach_sqr", longint'(stateO), 3);
        #2 reset = 1'b0;
        #1;
        chk("rst.flags", longint'({busy, done, err, mm_start}), 0);
        chk("rst.y", longint'(y), 0);
        chk("rst.mm_ab", longint'(mm_a | mm_b), 0);
        chk("rst.state", longint'(stateO), 0);
        @(negedge clk); reset = 1'b1;
        d0 = n_done; s0 = n_start;
        k = 0;
        while (mdl_busy != 0 && k < 40) begin @(negedge clk); k++; end
        chk("rst.model_drained", longint'(mdl_busy), 0);
        repeat (2) @(negedge clk);
        chk("rst.late_done_state", longint'(stateO), 0);
        chk("rst.late_done_pulses", longint'((n_done - d0) + (n_start - s0)), 0);
        run_vec(vt[1], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequences one Montgomery multiplier to compute y = msg^e mod N by left-to-right square-and-multiply for the RSA datapath.
- Owns operand registers, the exponent bit scan, and the multiplier start/done handshake.
- The multiplier computes mm_y = mm_a·mm_b·R⁻¹ mod N, where R = 2^n is fixed by the multiplier.
- The host supplies r2 = R² mod N, precomputed.

Parameters:
- bits, 31, MSB index of msg/N/r2/y and the multiplier operands.
- ebits, 31, MSB index of exponent e.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request pulse; sampled only in IDLE.
- msg  in  bits+1  base.
- e  in  ebits+1  exponent.
- N  in  bits+1  modulus; must be odd.
- r2  in  bits+1  R² mod N.
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.
- err  out  1  valid with done; 1 = N even, operation rejected.
- y  out  bits+1  result; held until the next accepted start.
- mm_a, mm_b  out  bits+1  multiplier operands; stable from mm_start until mm_done.
- mm_start  out  1  single-cycle multiplier request.
- mm_done  in  1  single-cycle multiplier completion; mm_y valid in that cycle.
- mm_y  in  bits+1  multiplier result.
- stateO  out  3  current state encoding, for debug and the host poll.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, err, mm_start = 0; y, mm_a, mm_b, internal X/A registers, bit index = 0.
- State encoding:
  - IDLE=0
  - CONV_X=1
  - CONV_A=2
  - SQR=3
  - MUL=4
  - CONV_OUT=5
  - FIN=6
- Each multiply state has an ISSUE cycle and a WAIT phase:
  - ISSUE: drive mm_a/mm_b, pulse mm_start for exactly one cycle.
  - WAIT: hold the operands until mm_done.
- IDLE + start (cycle t):
  - Latch msg, e, N, r2; clear err.
  - If N[0]=0: go to FIN with err=1 and y=0; done pulses at t+1; no mm_start is ever issued.
  - Else: go to CONV_X; busy=1 from t+1.
- CONV_X: operands (msg, r2) → X = msg·R mod N.
- CONV_A: operands (r2, 1) → A = R mod N; then i = ebits, go to SQR.
- SQR: operands (A, A) → A. Then:
  - if e[i]=1, go to MUL;
  - else if i=0, go to CONV_OUT;
  - else decrement i and re-enter SQR.
- MUL: operands (A, X) → A. Then:
  - if i=0, go to CONV_OUT;
  - else decrement i and go to SQR.
- CONV_OUT: operands (A, 1) → y.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Issue timing:
  - mm_done captured at cycle k → the next mm_start is at cycle k+1.
  - The final mm_done at cycle k → y valid and done=1 at cycle k+1.
- Transaction count: 3 + (ebits+1) + popcount(e). All exponent bits are scanned; no leading-zero skip, because squaring R mod N is an identity.
- e=0: y = 1 (for N > 1).
- mm_done outside WAIT (IDLE, ISSUE, FIN) is ignored.
- start while busy is ignored; latched operands are unchanged.
- Reset mid-operation:
  - Immediate abort to IDLE.
  - A late mm_done from the aborted transaction is ignored.
  - The next start runs from a clean state.
- Width rules:
  - i is a down-counter of width clog2(ebits+1).
  - All operands are carried at bits+1 width; no truncation inside this block.
  - Modular reduction is entirely the multiplier's job.
- busy = 1 in states CONV_X..CONV_OUT, 0 in IDLE and FIN.

Decomposition:
- Shared package holds:
  - state encodings (IDLE..FIN);
  - constant ONE = 1 at bits+1 width;
  - the mm_* handshake signal definitions, reused by the multiplier wrapper.
- One natural sub-module: mm_issue — a per-transaction ISSUE/WAIT handshake FSM that latches operands, pulses mm_start, and raises a one-cycle captured flag with the result.
- The top level holds the exponent scan FSM and the bit counter.

Test Plan:
- The bench uses a behavioural multiplier with R = 2^6 and randomized mm_done latency of 1–20 cycles.
- Test 1: N=33, r2=4, msg=5, e=3 → y=26, err=0; exactly 3+32+2=37 mm_start pulses; done one cycle after the final mm_done.
- Test 2: N=61, r2=9, msg=4, e=13 → y=19; mm_a/mm_b never change between mm_start and mm_done.
- Test 3: N=33, r2=4, msg=7, e=0 → y=1 after 35 transactions. Then msg=0, e=5 → y=0.
- Test 4: N=32 (even), start → err=1, y=0, done at t+1, zero mm_start pulses.
- Test 5: start pulses while busy are ignored (y still correct for the original operands). Also pulse mm_done spuriously in IDLE → no state change.
- Test 6: assert reset during SQR. Check:
  - all outputs 0 asynchronously;
  - the in-flight mm_done arriving after reset release is ignored;
  - a new start (N=61, r2=9, msg=4, e=13) gives y=19.
